// File: rtl/inst_fetch_req_way0_pkg.sv
// Shared types and constants for the way0 instruction-fetch request stage.
// Optional feature macro used by this slice: INST_FETCH_REQ_PERF_CNT_EN.
package if_pkg;

    localparam int XLEN = 32;

    // PC value loaded on reset unless the top overrides RESET_PC.
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Raw state encodings, kept as plain constants for older tooling.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef enum logic [0:0] {
        RUN   = ST_RUN,
        FLUSH = ST_FLUSH
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_req_way0_if.sv
// Instruction-memory bus between the fetch request stage and memory.
//
// Handshake: the fetch stage holds request_o with a stable instAddr_fetch_o;
// a request is accepted in any cycle where request_o and grant_i are both
// high. Each accepted request is answered later by exactly one cycle with
// rvalid_i high carrying rdata_i, in the same order as the grants. There is
// no backpressure on responses: the fetch stage always takes rvalid_i.
interface inst_fetch_req_way0_if;

    logic                     request_o;
    logic [if_pkg::XLEN-1:0]  instAddr_fetch_o;
    logic                     grant_i;
    logic                     rvalid_i;
    logic [if_pkg::XLEN-1:0]  rdata_i;

    // Fetch-stage side.
    modport master (
        output request_o,
        output instAddr_fetch_o,
        input  grant_i,
        input  rvalid_i,
        input  rdata_i
    );

    // Instruction-memory side.
    modport slave (
        input  request_o,
        input  instAddr_fetch_o,
        output grant_i,
        output rvalid_i,
        output rdata_i
    );

endinterface

// File: rtl/inst_fetch_req_way0_addr_queue.sv
// Small in-order FIFO holding the addresses of requests that memory has
// accepted but not yet answered. Up to 4 entries; DEPTH selects how many
// are used. clear wins over push/pop; pop on empty and push on full
// (without a simultaneous pop) are ignored.
module if_addr_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = XLEN
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         clear,
    output logic [W-1:0] head,
    output logic [2:0]   count
);

    localparam logic [2:0] DEPTH_L = 3'(DEPTH);
    localparam logic [1:0] LAST_L  = 2'(DEPTH - 1);

    logic [W-1:0] mem [0:3];
    logic [1:0]   rd_ptr;
    logic [1:0]   wr_ptr;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 3'd0);
    assign do_push = push && ((count < DEPTH_L) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_L) ? 2'd0 : p + 2'd1;
    endfunction

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (clear) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_req_way0.sv
// Way0 instruction-fetch request stage: owns the PC, issues in-order
// requests to instruction memory, pairs responses with their addresses and
// hands {inst, addr, valid} to the fetch buffer. A jump reloads the PC and
// discards any responses still in flight (FLUSH state).
// Optional feature macro: INST_FETCH_REQ_PERF_CNT_EN adds perfIssued_o and
// perfDropped_o event counters.
// MAX_OUTSTANDING legal range is 1..4 and must not exceed the downstream
// buffer slack, since ready_i does not stall responses already in flight.
module inst_fetch_req_way0
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int              PC_STEP         = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  jumpFlag_i,
    input  logic [XLEN-1:0]       jumpAddr_i,
    input  logic                  ready_i,
    inst_fetch_req_way0_if.master mem,
    output logic                  valid_o,
    output logic [XLEN-1:0]       inst_fetch_o,
    output logic [XLEN-1:0]       instAddr_o,
`ifdef INST_FETCH_REQ_PERF_CNT_EN
    output logic [31:0]           perfIssued_o,
    output logic [31:0]           perfDropped_o,
`endif
    output fetch_state_t          dbg_state,
    output logic [2:0]            dbg_outstanding
);

    localparam logic [2:0]      MAX_OUT_L = 3'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0] STEP_L    = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc;
    fetch_state_t    state;
    logic [2:0]      drop_cnt;
    logic [2:0]      q_count;
    logic [XLEN-1:0] q_head;
    logic [2:0]      outstanding;
    logic [2:0]      drop_next;
    logic            issue;
    logic            resp_hit;
    logic            q_pop;

    // In FLUSH the queue is already cleared and the drop counter is the
    // number of responses still owed by memory.
    assign outstanding = (state == FLUSH) ? drop_cnt : q_count;

    assign mem.request_o        = (state == RUN) && ready_i && !jumpFlag_i
                                  && (outstanding < MAX_OUT_L);
    assign mem.instAddr_fetch_o = pc;

    assign issue     = mem.request_o && mem.grant_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_hit  = mem.rvalid_i && (outstanding != 3'd0);
    assign drop_next = outstanding - {2'b00, resp_hit};
    assign q_pop     = (state == RUN) && !jumpFlag_i && resp_hit;

    assign dbg_state       = state;
    assign dbg_outstanding = outstanding;

    if_addr_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (XLEN)
    ) u_addr_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (issue),
        .push_data (pc),
        .pop       (q_pop),
        .clear     (jumpFlag_i),
        .head      (q_head),
        .count     (q_count)
    );

    // Program counter: redirect on jump, otherwise advance on each issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (jumpFlag_i) begin
            pc <= jumpAddr_i;
        end else if (issue) begin
            pc <= pc + STEP_L;
        end
    end

    // RUN/FLUSH control and count of stale responses to discard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            drop_cnt <= 3'd0;
        end else if (jumpFlag_i) begin
            drop_cnt <= drop_next;
            state    <= (drop_next != 3'd0) ? FLUSH : RUN;
        end else if ((state == FLUSH) && resp_hit) begin
            drop_cnt <= drop_cnt - 3'd1;
            if (drop_cnt == 3'd1) begin
                state <= RUN;
            end
        end
    end

    // Delivery register: one-cycle valid pulse, data holds between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_o      <= 1'b0;
            inst_fetch_o <= '0;
            instAddr_o   <= '0;
        end else begin
            valid_o <= q_pop;
            if (q_pop) begin
                inst_fetch_o <= mem.rdata_i;
                instAddr_o   <= q_head;
            end
        end
    end

`ifdef INST_FETCH_REQ_PERF_CNT_EN
    // Event counters for accepted requests and discarded responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perfIssued_o  <= '0;
            perfDropped_o <= '0;
        end else begin
            if (issue) begin
                perfIssued_o <= perfIssued_o + 32'd1;
            end
            if (resp_hit && (jumpFlag_i || (state == FLUSH))) begin
                perfDropped_o <= perfDropped_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_req_way0.sv
// Directed bench for inst_fetch_req_way0 with hand-computed expectations.
module tb_inst_fetch_req_way0;
    import if_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         jumpFlag_i;
    logic [31:0]  jumpAddr_i;
    logic         ready_i;
    logic         valid_o;
    logic [31:0]  inst_fetch_o;
    logic [31:0]  instAddr_o;
    fetch_state_t dut_state;
    logic [2:0]   dut_outstanding;
`ifdef INST_FETCH_REQ_PERF_CNT_EN
    logic [31:0]  perf_issued;
    logic [31:0]  perf_dropped;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    inst_fetch_req_way0_if mem_if ();

    inst_fetch_req_way0 dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .jumpFlag_i      (jumpFlag_i),
        .jumpAddr_i      (jumpAddr_i),
        .ready_i         (ready_i),
        .mem             (mem_if.master),
        .valid_o         (valid_o),
        .inst_fetch_o    (inst_fetch_o),
        .instAddr_o      (instAddr_o),
`ifdef INST_FETCH_REQ_PERF_CNT_EN
        .perfIssued_o    (perf_issued),
        .perfDropped_o   (perf_dropped),
`endif
        .dbg_state       (dut_state),
        .dbg_outstanding (dut_outstanding)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic drive(input logic rdy, input logic jmp, input logic [31:0] jaddr,
                         input logic gnt, input logic rv, input logic [31:0] rd);
        ready_i         = rdy;
        jumpFlag_i      = jmp;
        jumpAddr_i      = jaddr;
        mem_if.grant_i  = gnt;
        mem_if.rvalid_i = rv;
        mem_if.rdata_i  = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a delivery must carry the oldest expected address.
    task automatic expect_delivery(input string tag, input logic [31:0] exp_inst);
        logic [31:0] exp_addr;
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_inst"}, inst_fetch_o, exp_inst);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp_addr = exp_q.pop_front();
            check({tag, "_addr"}, instAddr_o, exp_addr);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #10;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_inst", inst_fetch_o, 32'h0);
        check("rst_addr", instAddr_o, 32'h0);
        check("rst_pc", mem_if.instAddr_fetch_o, 32'h8000_0000);
        check("rst_state", 32'(dut_state), 32'(RUN));
        check("rst_outst", 32'(dut_outstanding), 32'd0);
        reset_n = 1'b1;

        // Streaming: grant every cycle, response one cycle after each grant.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("s_req0", 32'(mem_if.request_o), 32'd1);
        check("s_addr0", mem_if.instAddr_fetch_o, 32'h8000_0000);
        exp_q.push_back(32'h8000_0000);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA000_0000);
        check("s_addr1", mem_if.instAddr_fetch_o, 32'h8000_0004);
        exp_q.push_back(32'h8000_0004);
        tick();
        expect_delivery("s_d0", 32'hA000_0000);
        check("s_outst", 32'(dut_outstanding), 32'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA000_0001);
        check("s_addr2", mem_if.instAddr_fetch_o, 32'h8000_0008);
        exp_q.push_back(32'h8000_0008);
        tick();
        expect_delivery("s_d1", 32'hA000_0001);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0002);
        tick();
        expect_delivery("s_d2", 32'hA000_0002);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("s_idle_valid", 32'(valid_o), 32'd0);
        check("s_hold_inst", inst_fetch_o, 32'hA000_0002);
        check("s_hold_addr", instAddr_o, 32'h8000_0008);
        check("s_outst0", 32'(dut_outstanding), 32'd0);

        // Outstanding limit: two grants without responses stop requests.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        exp_q.push_back(32'h8000_000C);
        tick();
        exp_q.push_back(32'h8000_0010);
        tick();
        check("lim_req", 32'(mem_if.request_o), 32'd0);
        check("lim_outst", 32'(dut_outstanding), 32'd2);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0000);
        tick();
        expect_delivery("lim_d0", 32'hB000_0000);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("lim_req_again", 32'(mem_if.request_o), 32'd1);
        check("lim_pc", mem_if.instAddr_fetch_o, 32'h8000_0014);

        // Jump with two outstanding: both later responses are dropped.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        check("j_outst2", 32'(dut_outstanding), 32'd2);
        drive(1'b1, 1'b1, 32'h8000_0100, 1'b1, 1'b0, 32'h0);
        check("j_req_jump", 32'(mem_if.request_o), 32'd0);
        tick();
        exp_q.delete();
        check("j_state", 32'(dut_state), 32'(FLUSH));
        check("j_drop", 32'(dut_outstanding), 32'd2);
        check("j_pc", mem_if.instAddr_fetch_o, 32'h8000_0100);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC000_0000);
        check("j_req_flush", 32'(mem_if.request_o), 32'd0);
        tick();
        check("j_drop_v0", 32'(valid_o), 32'd0);
        check("j_state1", 32'(dut_state), 32'(FLUSH));
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0001);
        tick();
        check("j_drop_v1", 32'(valid_o), 32'd0);
        check("j_state_run", 32'(dut_state), 32'(RUN));
        check("j_outst0", 32'(dut_outstanding), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("j_req_new", 32'(mem_if.request_o), 32'd1);
        check("j_addr_new", mem_if.instAddr_fetch_o, 32'h8000_0100);
        tick();

        // Jump coinciding with the only outstanding response.
        drive(1'b1, 1'b1, 32'h8000_0100, 1'b1, 1'b1, 32'hD000_0000);
        tick();
        check("jr_state", 32'(dut_state), 32'(RUN));
        check("jr_outst", 32'(dut_outstanding), 32'd0);
        check("jr_valid", 32'(valid_o), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("jr_req", 32'(mem_if.request_o), 32'd1);
        check("jr_addr", mem_if.instAddr_fetch_o, 32'h8000_0100);
        exp_q.push_back(32'h8000_0100);
        tick();

        // ready_i low blocks new requests but not delivery.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("rdy_req", 32'(mem_if.request_o), 32'd0);
        tick();
        check("rdy_pc", mem_if.instAddr_fetch_o, 32'h8000_0104);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE000_0000);
        tick();
        expect_delivery("rdy_d0", 32'hE000_0000);

        // PC wrap, then reset in the middle of a flush.
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        tick();
        check("w_pc", mem_if.instAddr_fetch_o, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        check("w_wrap", mem_if.instAddr_fetch_o, 32'h0000_0000);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
        tick();
        check("w_state", 32'(dut_state), 32'(FLUSH));
`ifdef INST_FETCH_REQ_PERF_CNT_EN
        check("perf_issued", perf_issued, 32'd10);
        check("perf_dropped", perf_dropped, 32'd3);
`endif
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hF000_0000);
        reset_n = 1'b0;
        #1;
        check("mr_valid", 32'(valid_o), 32'd0);
        check("mr_state", 32'(dut_state), 32'(RUN));
        check("mr_pc", mem_if.instAddr_fetch_o, 32'h8000_0000);
        check("mr_outst", 32'(dut_outstanding), 32'd0);
        check("mr_addr", instAddr_o, 32'h0);
        exp_q.delete();
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hF000_0001);
        tick();
        check("mr_stray_valid", 32'(valid_o), 32'd0);
        check("mr_stray_outst", 32'(dut_outstanding), 32'd0);
        check("mr_stray_state", 32'(dut_state), 32'(RUN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
